// File: rtl/top_pkg.sv
// Shared command/reply codes and state encodings for the UART glitch controller.
package top_pkg;

    localparam logic [7:0] CMD_PING      = 8'h00;
    localparam logic [7:0] CMD_GLITCH    = 8'h01;
    localparam logic [7:0] CMD_STATUS    = 8'h02;
    localparam logic [3:0] CMD_WIDTH_PFX = 4'h1;

    localparam logic [7:0] RPL_PING      = 8'h55;
    localparam logic [7:0] RPL_GLITCH    = 8'h01;
    localparam logic [7:0] RPL_ERR       = 8'hEE;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_WAIT_DELAY = 3'd1,
        ST_GLITCH     = 3'd2,
        ST_REPLY      = 3'd3,
        ST_WAIT_TX    = 3'd4
    } ctrl_state_e;

    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_START = 2'd1,
        RX_DATA  = 2'd2,
        RX_STOP  = 2'd3
    } rx_state_e;

    typedef enum logic [1:0] {
        TX_IDLE  = 2'd0,
        TX_START = 2'd1,
        TX_DATA  = 2'd2,
        TX_STOP  = 2'd3
    } tx_state_e;

    function automatic logic is_valid_cmd(input logic [7:0] b);
        return (b == CMD_PING) || (b == CMD_GLITCH) || (b == CMD_STATUS) ||
               (b[7:4] == CMD_WIDTH_PFX);
    endfunction

endpackage

// File: rtl/top_if.sv
// Pin bundle of the glitch controller: host/target lines in, UART/LED/debug out.
interface top_if;
    logic        ftdi_rx;
    logic        board1_rx;
    logic        ftdi_tx;
    logic        led;
    logic [15:0] debug_wing;

    modport master (output ftdi_rx, output board1_rx,
                    input  ftdi_tx, input  led, input debug_wing);
    modport slave  (input  ftdi_rx, input  board1_rx,
                    output ftdi_tx, output led, output debug_wing);
endinterface

// File: rtl/top_uart_tx.sv
// 8N1 UART transmitter, LSB first; rdy drops the cycle after a byte is latched.
module uart_tx
    import top_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] data_in,
    input  logic       en,
    output logic       dout,
    output logic       rdy
);

    localparam logic [15:0] BIT_LAST = 16'(CLKS_PER_BIT - 1);

    tx_state_e   r_state;
    logic [15:0] r_cnt;
    logic [2:0]  r_bit;
    logic [7:0]  r_shift;
    logic        r_dout;
    logic        r_rdy;

    assign dout = r_dout;
    assign rdy  = r_rdy;

    // Frame sequencer: start bit, eight data bits, stop bit, each BIT_LAST+1 cycles.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= TX_IDLE;
            r_cnt   <= 16'd0;
            r_bit   <= 3'd0;
            r_shift <= 8'h00;
            r_dout  <= 1'b1;
            r_rdy   <= 1'b1;
        end else begin
            case (r_state)
                TX_IDLE: begin
                    if (en && r_rdy) begin
                        r_shift <= data_in;
                        r_dout  <= 1'b0;
                        r_rdy   <= 1'b0;
                        r_cnt   <= 16'd0;
                        r_state <= TX_START;
                    end
                end
                TX_START: begin
                    if (r_cnt == BIT_LAST) begin
                        r_cnt   <= 16'd0;
                        r_bit   <= 3'd0;
                        r_dout  <= r_shift[0];
                        r_state <= TX_DATA;
                    end else begin
                        r_cnt <= r_cnt + 16'd1;
                    end
                end
                TX_DATA: begin
                    if (r_cnt == BIT_LAST) begin
                        r_cnt <= 16'd0;
                        if (r_bit == 3'd7) begin
                            r_dout  <= 1'b1;
                            r_state <= TX_STOP;
                        end else begin
                            r_bit   <= r_bit + 3'd1;
                            r_dout  <= r_shift[1];
                            r_shift <= r_shift >> 1;
                        end
                    end else begin
                        r_cnt <= r_cnt + 16'd1;
                    end
                end
                TX_STOP: begin
                    if (r_cnt == BIT_LAST) begin
                        r_cnt   <= 16'd0;
                        r_rdy   <= 1'b1;
                        r_state <= TX_IDLE;
                    end else begin
                        r_cnt <= r_cnt + 16'd1;
                    end
                end
                default: begin
                    r_state <= TX_IDLE;
                    r_dout  <= 1'b1;
                    r_rdy   <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: rtl/top.sv
// UART-commanded glitch controller: host receiver, command FSM, glitch pulse and replies.
module top
    import top_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868,
    parameter int GLITCH_DELAY = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ftdi_rx,
    input  logic        board1_rx,
    output logic        ftdi_tx,
    output logic        led,
    output logic [15:0] debug_wing
);

    localparam logic [15:0] BIT_LAST   = 16'(CLKS_PER_BIT - 1);
    localparam logic [15:0] HALF_LAST  = 16'(CLKS_PER_BIT / 2 - 1);
    localparam logic [15:0] DELAY_LAST = 16'(GLITCH_DELAY - 1);

    logic        r_rx_meta, r_rx_sync, r_rx_prev;
    logic        r_b1_meta, r_b1_sync;

    rx_state_e   r_rx_state;
    logic [15:0] r_rx_cnt;
    logic [2:0]  r_rx_bit;
    logic [7:0]  r_rx_shift;
    logic [7:0]  r_rx_byte;
    logic        r_rx_valid;

    ctrl_state_e r_state;
    logic [15:0] r_cnt;
    logic        r_glitch;
    logic [4:0]  r_width;
    logic [7:0]  r_gcount;
    logic        r_led;
    logic [7:0]  r_last;
    logic [7:0]  r_reply;
    logic        r_tx_en;
    logic        r_tx_seen_low;

    logic        w_tx_rst, w_tx_dout, w_tx_rdy, w_rx_busy;

    // Two-flop synchronizers; r_rx_prev gives the falling-edge reference.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_rx_meta <= 1'b1;
            r_rx_sync <= 1'b1;
            r_rx_prev <= 1'b1;
            r_b1_meta <= 1'b1;
            r_b1_sync <= 1'b1;
        end else begin
            r_rx_meta <= ftdi_rx;
            r_rx_sync <= r_rx_meta;
            r_rx_prev <= r_rx_sync;
            r_b1_meta <= board1_rx;
            r_b1_sync <= r_b1_meta;
        end
    end

    // Receiver: mid-bit sampling; a glitchy start or low stop bit drops the byte.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_rx_state <= RX_IDLE;
            r_rx_cnt   <= 16'd0;
            r_rx_bit   <= 3'd0;
            r_rx_shift <= 8'h00;
            r_rx_byte  <= 8'h00;
            r_rx_valid <= 1'b0;
        end else begin
            r_rx_valid <= 1'b0;
            case (r_rx_state)
                RX_IDLE: begin
                    if (!r_rx_sync && r_rx_prev) begin
                        r_rx_cnt   <= 16'd0;
                        r_rx_state <= RX_START;
                    end
                end
                RX_START: begin
                    if (r_rx_cnt == HALF_LAST) begin
                        r_rx_cnt   <= 16'd0;
                        r_rx_bit   <= 3'd0;
                        r_rx_state <= r_rx_sync ? RX_IDLE : RX_DATA;
                    end else begin
                        r_rx_cnt <= r_rx_cnt + 16'd1;
                    end
                end
                RX_DATA: begin
                    if (r_rx_cnt == BIT_LAST) begin
                        r_rx_cnt   <= 16'd0;
                        r_rx_shift <= {r_rx_sync, r_rx_shift[7:1]};
                        if (r_rx_bit == 3'd7) begin
                            r_rx_state <= RX_STOP;
                        end else begin
                            r_rx_bit <= r_rx_bit + 3'd1;
                        end
                    end else begin
                        r_rx_cnt <= r_rx_cnt + 16'd1;
                    end
                end
                RX_STOP: begin
                    if (r_rx_cnt == BIT_LAST) begin
                        r_rx_cnt   <= 16'd0;
                        r_rx_state <= RX_IDLE;
                        if (r_rx_sync) begin
                            r_rx_byte  <= r_rx_shift;
                            r_rx_valid <= 1'b1;
                        end
                    end else begin
                        r_rx_cnt <= r_rx_cnt + 16'd1;
                    end
                end
                default: r_rx_state <= RX_IDLE;
            endcase
        end
    end

    // Command FSM: decode in IDLE, time the glitch, hand the reply to the transmitter.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state       <= ST_IDLE;
            r_cnt         <= 16'd0;
            r_glitch      <= 1'b0;
            r_width       <= 5'd1;
            r_gcount      <= 8'h00;
            r_led         <= 1'b1;
            r_last        <= 8'h00;
            r_reply       <= 8'h00;
            r_tx_en       <= 1'b0;
            r_tx_seen_low <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_tx_en <= 1'b0;
                    if (r_rx_valid) begin
                        r_last <= r_rx_byte;
                        if (is_valid_cmd(r_rx_byte)) begin
                            r_led <= ~r_led;
                        end
                        if (r_rx_byte == CMD_PING) begin
                            r_reply <= RPL_PING;
                            r_state <= ST_REPLY;
                        end else if (r_rx_byte == CMD_GLITCH) begin
                            r_cnt   <= 16'd0;
                            r_state <= ST_WAIT_DELAY;
                        end else if (r_rx_byte == CMD_STATUS) begin
                            r_reply <= {r_gcount[6:0], r_b1_sync};
                            r_state <= ST_REPLY;
                        end else if (r_rx_byte[7:4] == CMD_WIDTH_PFX) begin
                            r_width <= {1'b0, r_rx_byte[3:0]} + 5'd1;
                            r_reply <= r_rx_byte;
                            r_state <= ST_REPLY;
                        end else begin
                            r_reply <= RPL_ERR;
                            r_state <= ST_REPLY;
                        end
                    end
                end
                ST_WAIT_DELAY: begin
                    if (r_cnt == DELAY_LAST) begin
                        r_cnt    <= 16'd0;
                        r_glitch <= 1'b1;
                        r_gcount <= r_gcount + 8'd1;
                        r_state  <= ST_GLITCH;
                    end else begin
                        r_cnt <= r_cnt + 16'd1;
                    end
                end
                ST_GLITCH: begin
                    if (r_cnt == 16'(r_width) - 16'd1) begin
                        r_cnt    <= 16'd0;
                        r_glitch <= 1'b0;
                        r_reply  <= RPL_GLITCH;
                        r_state  <= ST_REPLY;
                    end else begin
                        r_cnt <= r_cnt + 16'd1;
                    end
                end
                ST_REPLY: begin
                    if (w_tx_rdy) begin
                        r_tx_en       <= 1'b1;
                        r_tx_seen_low <= 1'b0;
                        r_state       <= ST_WAIT_TX;
                    end
                end
                ST_WAIT_TX: begin
                    r_tx_en <= 1'b0;
                    if (!w_tx_rdy) begin
                        r_tx_seen_low <= 1'b1;
                    end else if (r_tx_seen_low) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_state  <= ST_IDLE;
                    r_glitch <= 1'b0;
                    r_tx_en  <= 1'b0;
                end
            endcase
        end
    end

    assign w_tx_rst  = ~rst;
    assign w_rx_busy = (r_rx_state != RX_IDLE);

    uart_tx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_uart_tx (
        .clk     (clk),
        .rst     (w_tx_rst),
        .data_in (r_reply),
        .en      (r_tx_en),
        .dout    (w_tx_dout),
        .rdy     (w_tx_rdy)
    );

    assign ftdi_tx    = w_tx_dout;
    assign led        = r_led;
    assign debug_wing = {r_last, 2'b00, ~w_tx_rdy, w_rx_busy, r_b1_sync,
                         w_tx_dout, r_rx_sync, r_glitch};

endmodule

// File: tb/tb_top.sv
// Randomized command bench for top with a byte-level reference model and UART/pulse monitors.
module tb_top;
    localparam int CPB = 16;
    localparam int GD  = 6;

    logic clk = 1'b0;
    logic rst = 1'b0;
    top_if bus ();

    top #(.CLKS_PER_BIT(CPB), .GLITCH_DELAY(GD)) dut (
        .clk        (clk),
        .rst        (rst),
        .ftdi_rx    (bus.ftdi_rx),
        .board1_rx  (bus.board1_rx),
        .ftdi_tx    (bus.ftdi_tx),
        .led        (bus.led),
        .debug_wing (bus.debug_wing)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    logic [8:0] tx_q[$];
    int         gd_q[$];
    int         gw_q[$];

    int         m_width = 1;
    int         m_count = 0;
    logic       m_led   = 1'b1;
    logic [7:0] m_last  = 8'h00;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Decode frames on ftdi_tx into {stop, data}.
    initial begin : tx_mon
        logic [7:0] b;
        forever begin
            @(negedge clk);
            if (rst && bus.ftdi_tx == 1'b0) begin
                repeat (CPB / 2) @(negedge clk);
                if (bus.ftdi_tx == 1'b0) begin
                    for (int i = 0; i < 8; i++) begin
                        repeat (CPB) @(negedge clk);
                        b[i] = bus.ftdi_tx;
                    end
                    repeat (CPB) @(negedge clk);
                    tx_q.push_back({bus.ftdi_tx, b});
                end
            end
        end
    end

    // Measure each glitch pulse: delay from end of receive, and width.
    initial begin : g_mon
        int   cyc, t_fall, t_rise;
        logic pb, pg;
        cyc = 0; t_fall = 0; t_rise = 0; pb = 1'b0; pg = 1'b0;
        forever begin
            @(negedge clk);
            cyc++;
            if (pb && !bus.debug_wing[4]) t_fall = cyc;
            if (!pg && bus.debug_wing[0]) t_rise = cyc;
            if (pg && !bus.debug_wing[0]) begin
                gd_q.push_back(t_rise - t_fall);
                gw_q.push_back(cyc - t_rise);
            end
            pb = bus.debug_wing[4];
            pg = bus.debug_wing[0];
        end
    end

    task automatic send_frame(input logic [7:0] b, input logic stop);
        @(negedge clk);
        bus.ftdi_rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            bus.ftdi_rx = b[i];
            repeat (CPB) @(negedge clk);
        end
        bus.ftdi_rx = stop;
        repeat (CPB) @(negedge clk);
        bus.ftdi_rx = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    // Reference behaviour of one command byte taken while idle.
    task automatic model_cmd(input logic [7:0] b, input logic board,
                             output logic [7:0] rep, output logic is_g);
        int v;
        v    = b;
        is_g = 1'b0;
        if (v == 0) begin
            rep = 8'h55;
        end else if (v == 1) begin
            m_count = (m_count + 1) % 256;
            rep = 8'h01;
            is_g = 1'b1;
        end else if (v == 2) begin
            rep = 8'(((m_count % 128) * 2) + board);
        end else if (v >= 16 && v < 32) begin
            m_width = v - 15;
            rep = b;
        end else begin
            rep = 8'hEE;
        end
        if (v <= 2 || (v >= 16 && v < 32)) m_led = ~m_led;
        m_last = b;
    endtask

    task automatic run_cmd(input logic [7:0] b, input int board_sel);
        logic       board, is_g;
        logic [7:0] rep;
        int         k;
        board = (board_sel == 2) ? 1'($urandom_range(0, 1)) : 1'(board_sel);
        bus.board1_rx = board;
        repeat (4) @(negedge clk);
        model_cmd(b, board, rep, is_g);
        send_frame(b, 1'b1);
        for (k = 0; k < 40 * CPB && tx_q.size() == 0; k++) @(negedge clk);
        chk("reply_seen", tx_q.size(), 1);
        if (tx_q.size() > 0) chk("reply", tx_q.pop_front(), {1'b1, rep});
        if (is_g) begin
            chk("pulse_seen", gd_q.size(), 1);
            if (gd_q.size() > 0) begin
                chk("pulse_delay", gd_q.pop_front(), GD + 1);
                chk("pulse_width", gw_q.pop_front(), m_width);
            end
        end else begin
            chk("no_pulse", gd_q.size(), 0);
        end
        repeat (CPB) @(negedge clk);
        chk("led", bus.led, m_led);
        chk("last_byte", bus.debug_wing[15:8], m_last);
        chk("glitch_idle", bus.debug_wing[0], 1'b0);
    endtask

    task automatic run_bad_frame(input logic [7:0] b);
        send_frame(b, 1'b0);
        repeat (20 * CPB) @(negedge clk);
        chk("framing_no_reply", tx_q.size(), 0);
        chk("framing_last_kept", bus.debug_wing[15:8], m_last);
        chk("framing_led", bus.led, m_led);
    endtask

    initial begin : main
        logic [7:0] b;
        int         r, hi, k;
        bus.ftdi_rx   = 1'b1;
        bus.board1_rx = 1'b0;
        rst = 1'b0;
        repeat (5) @(negedge clk);
        chk("rst_tx", bus.ftdi_tx, 1'b1);
        chk("rst_led", bus.led, 1'b1);
        chk("rst_glitch", bus.debug_wing[0], 1'b0);
        chk("rst_last", bus.debug_wing[15:8], 8'h00);
        chk("rst_tx_busy", bus.debug_wing[5], 1'b0);
        chk("rst_rx_busy", bus.debug_wing[4], 1'b0);
        rst = 1'b1;
        repeat (5) @(negedge clk);

        run_cmd(8'h00, 2);
        run_cmd(8'h10, 2);
        run_cmd(8'h01, 2);
        run_cmd(8'h1F, 2);
        run_cmd(8'h01, 2);
        run_cmd(8'h02, 1);
        run_cmd(8'h7A, 2);
        run_cmd(8'h01, 2);
        run_bad_frame(8'h33);

        for (int i = 0; i < 30; i++) begin
            r = $urandom_range(0, 9);
            case (r)
                0, 1:    run_cmd(8'h00, 2);
                2, 3:    run_cmd(8'h01, 2);
                4:       run_cmd(8'h02, 2);
                5, 6:    run_cmd(8'h10 | 8'($urandom_range(0, 15)), 2);
                7, 8: begin
                    b = 8'($urandom_range(0, 255));
                    while (b <= 8'h02 || b[7:4] == 4'h1) b = 8'($urandom_range(0, 255));
                    run_cmd(b, 2);
                end
                default: run_bad_frame(8'($urandom_range(0, 255)));
            endcase
        end

        // Reset in the middle of a 16-cycle pulse.
        run_cmd(8'h1F, 2);
        send_frame(8'h01, 1'b1);
        for (k = 0; k < 40 * CPB && !bus.debug_wing[0]; k++) @(negedge clk);
        chk("rst_pulse_started", bus.debug_wing[0], 1'b1);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_glitch", bus.debug_wing[0], 1'b0);
        chk("midrst_tx", bus.ftdi_tx, 1'b1);
        chk("midrst_led", bus.led, 1'b1);
        chk("midrst_last", bus.debug_wing[15:8], 8'h00);
        repeat (5) @(negedge clk);
        rst = 1'b1;
        hi = 0;
        repeat (GD + 40) begin
            @(negedge clk);
            if (bus.debug_wing[0]) hi++;
        end
        chk("no_pulse_after_rst", hi, 0);
        tx_q.delete();
        gd_q.delete();
        gw_q.delete();
        m_width = 1;
        m_count = 0;
        m_led   = 1'b1;
        m_last  = 8'h00;

        run_cmd(8'h02, 1);
        run_cmd(8'h01, 2);
        run_cmd(8'h02, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
